player_mover: RTL and testbench

Sequential player-position controller for the maze game. It turns one-hot direction key levels into single-cell move requests and presents the requested direction plus the current player box to the combinational `collision` checker. It commits the move only when `wallblks` is low and the screen edge is not reached. It sits between the keyboard/key-sync logic and both the `collision` instance and the VGA sprite drawer, and it flags arrival at the goal cell.

---
 rtl/maze_pkg.sv | 48 ++++
 rtl/repeat_timer.sv | 38 +++
 rtl/player_mover.sv | 205 ++++++++++++++++++++
 tb/tb_player_mover.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze game blocks.
//
// Contents:
//   SCREEN_W, SCREEN_H  visible screen size in pixels
//   CELL_W, CELL_H      maze cell size in pixels
//   dir_t               a single move direction, NONE when no move is wanted
//   mover_state_t       phases of the player_mover controller
//   onehot_dir()        turns the four key levels into a direction, or NONE
//                       unless exactly one key is down
package maze_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CELL_W   = 32;
    localparam int CELL_H   = 30;

    typedef enum logic [2:0] {
        NONE,
        LEFT,
        UP,
        DOWN,
        RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DONE
    } mover_state_t;

    // A chord of keys (or no key) is treated as "no request" so the
    // player never moves diagonally or in an ambiguous direction.
    function automatic dir_t onehot_dir(input logic kl, input logic ku,
                                        input logic kd, input logic kr);
        dir_t d;
        d = NONE;
        case ({kl, ku, kd, kr})
            4'b1000: d = LEFT;
            4'b0100: d = UP;
            4'b0010: d = DOWN;
            4'b0001: d = RIGHT;
            default: d = NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/repeat_timer.sv
// Hold-time counter for key auto-repeat.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high reset (count back to 0)
//   clear    returns the count to 0; wins over enable
//   enable   advances the count by one each cycle
//   expired  high while the count sits at REPEAT_CYCLES-1
module repeat_timer #(
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REPEAT_CYCLES - 1);

    logic [CW-1:0] count;

    // The owner clears the counter when it expires, so the count never
    // has to run past LAST and CW bits are always enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/player_mover.sv
// Player-position controller for the maze game.
//
// Turns one-hot key levels into single-cell move requests, shows the
// requested direction and the current box to the external collision
// checker, and commits the move only when the checker reports free and
// the box is not already against the screen edge. Holding a key repeats
// the move every REPEAT_CYCLES+1 cycles. Reaching the goal cell freezes
// the player until reset.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   key_left/up/down/right      synchronised key levels
//   wallblks                    collision result for the presented request
//   left/up/down/right          direction presented to collision (one cycle)
//   xFlr/xCeil/yFlr/yCeil       current player box in pixels
//   moved                       one-cycle pulse when a move commits
//   blocked                     one-cycle pulse when a request is refused
//   at_goal                     high while the box sits on the goal cell
module player_mover #(
    parameter int CELL_W        = 32,
    parameter int CELL_H        = 30,
    parameter int START_X       = 0,
    parameter int START_Y       = 0,
    parameter int GOAL_X        = 608,
    parameter int GOAL_Y        = 450,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_left,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_right,
    input  logic       wallblks,
    output logic       left,
    output logic       up,
    output logic       down,
    output logic       right,
    output logic [9:0] xFlr,
    output logic [9:0] xCeil,
    output logic [9:0] yFlr,
    output logic [9:0] yCeil,
    output logic       moved,
    output logic       blocked,
    output logic       at_goal
);
    import maze_pkg::*;

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_REQ  = 2'(REQ);
    localparam logic [1:0] S_HOLD = 2'(HOLD);
    localparam logic [1:0] S_DONE = 2'(DONE);

    localparam logic [9:0] STEP_X   = 10'(CELL_W);
    localparam logic [9:0] STEP_Y   = 10'(CELL_H);
    localparam logic [9:0] EDGE_X   = 10'(SCREEN_W);
    localparam logic [9:0] EDGE_Y   = 10'(SCREEN_H);
    localparam logic [9:0] GOAL_XV  = 10'(GOAL_X);
    localparam logic [9:0] GOAL_YV  = 10'(GOAL_Y);
    localparam logic       START_AT = (START_X == GOAL_X) && (START_Y == GOAL_Y);

    logic [1:0] state;
    dir_t       dir;
    dir_t       keydir;
    logic       held;
    logic       edge_hit;
    logic       refused;
    logic       req_goal;
    logic       timer_en;
    logic       timer_clr;
    logic       expired;
    logic [9:0] nxf, nxc, nyf, nyc;

    assign keydir = onehot_dir(key_left, key_up, key_down, key_right);

    // The latched direction is only shown to collision during the single
    // REQ cycle; the rest of the time all four lines stay low.
    assign left  = (state == S_REQ) && (dir == LEFT);
    assign up    = (state == S_REQ) && (dir == UP);
    assign down  = (state == S_REQ) && (dir == DOWN);
    assign right = (state == S_REQ) && (dir == RIGHT);

    // Only the key that started the move keeps the repeat alive; any other
    // key pressed meanwhile is ignored.
    always_comb begin
        held = 1'b0;
        case (dir)
            LEFT:    held = key_left;
            UP:      held = key_up;
            DOWN:    held = key_down;
            RIGHT:   held = key_right;
            default: held = 1'b0;
        endcase
    end

    // Candidate box for the pending request. collision does not shift the
    // box past the screen edge and would report free there, so the edge is
    // checked here as well. With the edge excluded the 10-bit add/subtract
    // can never wrap.
    always_comb begin
        nxf      = xFlr;
        nxc      = xCeil;
        nyf      = yFlr;
        nyc      = yCeil;
        edge_hit = 1'b0;
        case (dir)
            LEFT:    edge_hit = (xFlr == 10'd0);
            UP:      edge_hit = (yFlr == 10'd0);
            DOWN:    edge_hit = (yCeil == EDGE_Y);
            RIGHT:   edge_hit = (xCeil == EDGE_X);
            default: edge_hit = 1'b0;
        endcase
        refused = wallblks || edge_hit;
        if (!refused) begin
            case (dir)
                LEFT: begin
                    nxf = xFlr - STEP_X;
                    nxc = xCeil - STEP_X;
                end
                UP: begin
                    nyf = yFlr - STEP_Y;
                    nyc = yCeil - STEP_Y;
                end
                DOWN: begin
                    nyf = yFlr + STEP_Y;
                    nyc = yCeil + STEP_Y;
                end
                RIGHT: begin
                    nxf = xFlr + STEP_X;
                    nxc = xCeil + STEP_X;
                end
                default: begin
                    nxf = xFlr;
                    nxc = xCeil;
                end
            endcase
        end
        req_goal = (nxf == GOAL_XV) && (nyf == GOAL_YV);
    end

    // The timer only runs while holding; it restarts whenever the key is
    // released or a repeat request is issued.
    assign timer_en  = (state == S_HOLD);
    assign timer_clr = !timer_en || !held || expired;

    repeat_timer #(
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clr),
        .enable (timer_en),
        .expired(expired)
    );

    // Main controller. Position and at_goal change only in REQ, so at_goal
    // can be loaded from the candidate box at the same time as the box.
    // In HOLD the release check comes first so that letting go on the
    // expiry cycle never produces one extra move.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            dir     <= NONE;
            xFlr    <= 10'(START_X);
            xCeil   <= 10'(START_X + CELL_W);
            yFlr    <= 10'(START_Y);
            yCeil   <= 10'(START_Y + CELL_H);
            moved   <= 1'b0;
            blocked <= 1'b0;
            at_goal <= START_AT;
        end else begin
            moved   <= 1'b0;
            blocked <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (keydir != NONE) begin
                        dir   <= keydir;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    xFlr    <= nxf;
                    xCeil   <= nxc;
                    yFlr    <= nyf;
                    yCeil   <= nyc;
                    moved   <= !refused;
                    blocked <= refused;
                    at_goal <= req_goal;
                    state   <= req_goal ? S_DONE : S_HOLD;
                end
                S_HOLD: begin
                    if (!held) begin
                        state <= S_IDLE;
                    end else if (expired) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_mover.sv
// Self-checking bench for player_mover with a short repeat time.
// A behavioural maze (cell grid with random walls) stands in for the
// collision block; a cell-level model predicts when moves and refusals
// happen and where the player ends up.
module tb_player_mover;

    localparam int R    = 4;
    localparam int COLS = 20;
    localparam int ROWS = 16;
    localparam int GX   = 19;
    localparam int GY   = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, key_left, key_up, key_down, key_right, wallblks;
    logic       left, up, down, right, moved, blocked, at_goal;
    logic [9:0] xFlr, xCeil, yFlr, yCeil;

    logic       reset2, k2l, k2u, k2d, k2r, wb2;
    logic       left2, up2, down2, right2, moved2, blocked2, at_goal2;
    logic [9:0] xFlr2, xCeil2, yFlr2, yCeil2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit monOn    = 0;
    bit noise    = 0;
    bit walls [COLS][ROWS];
    int movedQ[$];
    int blockedQ[$];
    int m2Count = 0;
    int b2Count = 0;
    int mx, my;
    bit mDone;
    int tx, ty;

    player_mover #(
        .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .reset(reset),
        .key_left(key_left), .key_up(key_up), .key_down(key_down), .key_right(key_right),
        .wallblks(wallblks),
        .left(left), .up(up), .down(down), .right(right),
        .xFlr(xFlr), .xCeil(xCeil), .yFlr(yFlr), .yCeil(yCeil),
        .moved(moved), .blocked(blocked), .at_goal(at_goal)
    );

    player_mover #(
        .START_X(608), .START_Y(420), .REPEAT_CYCLES(R)
    ) dut2 (
        .clk(clk), .reset(reset2),
        .key_left(k2l), .key_up(k2u), .key_down(k2d), .key_right(k2r),
        .wallblks(wb2),
        .left(left2), .up(up2), .down(down2), .right(right2),
        .xFlr(xFlr2), .xCeil(xCeil2), .yFlr(yFlr2), .yCeil(yCeil2),
        .moved(moved2), .blocked(blocked2), .at_goal(at_goal2)
    );

    // Stand-in for collision: shift the box one cell in the presented
    // direction and look the target cell up in the wall map. Off-screen
    // targets read as free, like the real checker. With no direction the
    // result is random, since it must be ignored then.
    always_comb begin
        tx = int'(xFlr) / 32;
        ty = int'(yFlr) / 30;
        wallblks = noise;
        if (left || up || down || right) begin
            wallblks = 1'b0;
            if (left) tx = tx - 1;
            else if (right) tx = tx + 1;
            else if (up) ty = ty - 1;
            else ty = ty + 1;
            if (tx >= 0 && tx < COLS && ty >= 0 && ty < ROWS) wallblks = walls[tx][ty];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse recorder and direction-line sanity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        noise <= 1'($urandom);
        if (moved === 1'b1) movedQ.push_back(cyc);
        if (blocked === 1'b1) blockedQ.push_back(cyc);
        if (moved2 === 1'b1) m2Count++;
        if (blocked2 === 1'b1) b2Count++;
        if (monOn) checkOutput("dir_onehot", 32'($countones({left, up, down, right}) <= 1), 32'd1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setKeys(input logic [3:0] k);
        {key_left, key_up, key_down, key_right} = k;
    endtask

    task automatic doReset();
        setKeys(4'b0000);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        mx = 0;
        my = 0;
        mDone = 0;
    endtask

    task automatic checkBox(input string tag);
        checkOutput({tag, "_xflr"}, xFlr, mx * 32);
        checkOutput({tag, "_xceil"}, xCeil, mx * 32 + 32);
        checkOutput({tag, "_yflr"}, yFlr, my * 30);
        checkOutput({tag, "_yceil"}, yCeil, my * 30 + 30);
        checkOutput({tag, "_atgoal"}, at_goal, 32'(mx == GX && my == GY));
    endtask

    // Hold the keys for n sampling edges, release, and compare the pulse
    // times and final cell with the model. A held key requests at the
    // first edge after the press and every R+1 edges after that; each
    // outcome shows up one edge after its request.
    task automatic applyStimulus(input logic [3:0] k, input int n);
        int e, a, cx, cy;
        int expM[$];
        int expB[$];
        movedQ.delete();
        blockedQ.delete();
        e = cyc;
        setKeys(k);
        tick(n);
        setKeys(4'b0000);
        tick(2);
        if ($countones(k) == 1 && !mDone) begin
            a = 1 + (n - 1) / (R + 1);
            for (int j = 0; j < a; j++) begin
                if (mDone) break;
                cx = mx;
                cy = my;
                if (k[3]) cx--;
                else if (k[2]) cy--;
                else if (k[1]) cy++;
                else cx++;
                if (cx < 0 || cx >= COLS || cy < 0 || cy >= ROWS || walls[cx][cy]) begin
                    expB.push_back(e + 2 + j * (R + 1));
                end else begin
                    mx = cx;
                    my = cy;
                    expM.push_back(e + 2 + j * (R + 1));
                    if (mx == GX && my == GY) mDone = 1;
                end
            end
        end
        checkOutput("moved_count", movedQ.size(), expM.size());
        for (int i = 0; i < expM.size() && i < movedQ.size(); i++)
            checkOutput("moved_time", movedQ[i], expM[i]);
        checkOutput("blocked_count", blockedQ.size(), expB.size());
        for (int i = 0; i < expB.size() && i < blockedQ.size(); i++)
            checkOutput("blocked_time", blockedQ[i], expB[i]);
        checkBox("step");
    endtask

    initial begin
        logic [3:0] k;
        int n;
        reset = 1'b1;
        setKeys(4'b0000);
        reset2 = 1'b1;
        {k2l, k2u, k2d, k2r} = 4'b0000;
        wb2 = 1'b0;
        for (int x = 0; x < COLS; x++)
            for (int y = 0; y < ROWS; y++)
                walls[x][y] = ($urandom_range(0, 4) == 0);
        for (int y = 0; y < 4; y++) walls[0][y] = 1'b0;
        walls[1][0] = 1'b1;

        // Reset values.
        doReset();
        monOn = 1;
        checkOutput("rst_dirs", {left, up, down, right}, 4'b0000);
        checkOutput("rst_moved", moved, 0);
        checkOutput("rst_blocked", blocked, 0);
        checkBox("rst");

        // Right into the wall at x32-64: one refusal, box unchanged.
        setKeys(4'b0001);
        tick(1);
        checkOutput("right_dirs", {left, up, down, right}, 4'b0001);
        checkOutput("right_blk_early", blocked, 0);
        tick(1);
        checkOutput("right_dirs_fall", {left, up, down, right}, 4'b0000);
        checkOutput("right_blocked", blocked, 1);
        checkOutput("right_moved", moved, 0);
        checkBox("right");
        setKeys(4'b0000);
        tick(1);
        checkOutput("right_blk_fall", blocked, 0);

        // Single step down, two-cycle latency.
        doReset();
        setKeys(4'b0010);
        tick(1);
        checkOutput("down_dirs", {left, up, down, right}, 4'b0010);
        checkOutput("down_yflr_early", yFlr, 0);
        tick(1);
        checkOutput("down_moved", moved, 1);
        checkOutput("down_xflr", xFlr, 0);
        checkOutput("down_yflr", yFlr, 30);
        checkOutput("down_yceil", yCeil, 60);
        setKeys(4'b0000);
        tick(1);
        checkOutput("down_moved_fall", moved, 0);

        // Up at the top edge: refused even though collision reports free.
        doReset();
        setKeys(4'b0100);
        tick(1);
        checkOutput("up_dirs", {left, up, down, right}, 4'b0100);
        tick(1);
        checkOutput("up_blocked", blocked, 1);
        checkOutput("up_moved", moved, 0);
        checkBox("up");
        setKeys(4'b0000);
        tick(1);

        // Two keys together do nothing; dropping one yields one move.
        doReset();
        movedQ.delete();
        blockedQ.delete();
        setKeys(4'b1010);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checkOutput("chord_dirs", {left, up, down, right}, 4'b0000);
        end
        checkOutput("chord_pulses", movedQ.size() + blockedQ.size(), 0);
        applyStimulus(4'b0010, 1);

        // Held key repeats every R+1 cycles.
        doReset();
        applyStimulus(4'b0010, 12);
        checkOutput("hold12_yflr", yFlr, 90);

        // Random walk through the maze.
        doReset();
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 9) < 8) begin
                k = 4'b0001 << $urandom_range(0, 3);
            end else begin
                do k = 4'($urandom); while ($countones(k) < 2);
            end
            n = $urandom_range(1, 14);
            applyStimulus(k, n);
        end

        // Goal behaviour on the second instance.
        tick(1);
        reset2 = 1'b0;
        checkOutput("g_rst_x", xFlr2, 608);
        checkOutput("g_rst_xc", xCeil2, 640);
        checkOutput("g_rst_y", yFlr2, 420);
        checkOutput("g_rst_yc", yCeil2, 450);
        checkOutput("g_rst_goal", at_goal2, 0);
        m2Count = 0;
        b2Count = 0;
        k2d = 1'b1;
        tick(1);
        checkOutput("g_down_dir", down2, 1);
        tick(1);
        checkOutput("g_yflr", yFlr2, 450);
        checkOutput("g_yceil", yCeil2, 480);
        checkOutput("g_moved", moved2, 1);
        checkOutput("g_atgoal", at_goal2, 1);
        k2d = 1'b0;
        tick(2);
        k2u = 1'b1;
        tick(8);
        checkOutput("g_up_dir", up2, 0);
        k2u = 1'b0;
        tick(1);
        checkOutput("g_moves", m2Count, 1);
        checkOutput("g_blocks", b2Count, 0);
        checkOutput("g_frozen_y", yFlr2, 450);
        checkOutput("g_still_goal", at_goal2, 1);

        // Reset while holding restores the start cell.
        reset2 = 1'b1;
        tick(1);
        reset2 = 1'b0;
        k2l = 1'b1;
        tick(3);
        checkOutput("g_left_x", xFlr2, 576);
        reset2 = 1'b1;
        tick(1);
        reset2 = 1'b0;
        k2l = 1'b0;
        checkOutput("g_hold_rst_x", xFlr2, 608);
        checkOutput("g_hold_rst_xc", xCeil2, 640);
        checkOutput("g_hold_rst_y", yFlr2, 420);
        checkOutput("g_hold_rst_goal", at_goal2, 0);

        // Reset on the commit edge: nothing moves, nothing pulses.
        tick(1);
        m2Count = 0;
        b2Count = 0;
        k2l = 1'b1;
        tick(1);
        checkOutput("g_req_dir", left2, 1);
        reset2 = 1'b1;
        tick(1);
        checkOutput("g_req_rst_x", xFlr2, 608);
        checkOutput("g_req_rst_moved", moved2, 0);
        reset2 = 1'b0;
        k2l = 1'b0;
        tick(1);
        checkOutput("g_req_rst_pulses", m2Count + b2Count, 0);

        monOn = 0;
        $display("[TB] done");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
